wb_master_arbiter: RTL and testbench

Two-master Wishbone B4 (classic, single-slave-port) arbiter sharing the SoC data bus between the RV32I core's data port (master 0) and the UART debug/boot-loader master (master 1). It sits between the two masters and the data-bus interconnect that decodes to RAM, UART, GPIO and SPI-flash. Grants are round-robin and held for a whole `cyc` tenure. A bus-timeout watchdog terminates stalled transfers with an error so a missing slave cannot hang the core.

---
 rtl/wb_arb_pkg.sv | 14 +
 rtl/wb_bus_watchdog.sv | 39 +++
 rtl/wb_master_arbiter.sv | 143 ++++++++++++++
 tb/tb_wb_master_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types for the two-master Wishbone arbiter: FSM states and one-hot grant encodings.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_M0   = 2'b01;
    localparam logic [1:0] GRANT_M1   = 2'b10;

endpackage

// File: rtl/wb_bus_watchdog.sv
// Bus-timeout watchdog: counts unanswered strobe cycles and fires a one-cycle error pulse.
module wb_bus_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic stb,
    input  logic ack,
    input  logic err,
    input  logic clr,
    output logic fire
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES);
    localparam bit Enabled = (TIMEOUT_CYCLES != 0);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        fire  = Enabled && stb && (cnt_q == CntMax);
        cnt_d = cnt_q;
        // A firing compare also restarts the count so the pulse lasts exactly one cycle.
        if (!Enabled || clr || !stb || ack || err || fire) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wb_master_arbiter.sv
// Two-master round-robin Wishbone B4 classic arbiter with tenure-long grants and bus watchdog.
module wb_master_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    m0_cyc_i,
    input  logic                    m0_stb_i,
    input  logic                    m0_we_i,
    input  logic [ADDR_WIDTH-1:0]   m0_adr_i,
    input  logic [DATA_WIDTH-1:0]   m0_dat_i,
    input  logic [DATA_WIDTH/8-1:0] m0_sel_i,
    output logic [DATA_WIDTH-1:0]   m0_dat_o,
    output logic                    m0_ack_o,
    output logic                    m0_err_o,
    input  logic                    m1_cyc_i,
    input  logic                    m1_stb_i,
    input  logic                    m1_we_i,
    input  logic [ADDR_WIDTH-1:0]   m1_adr_i,
    input  logic [DATA_WIDTH-1:0]   m1_dat_i,
    input  logic [DATA_WIDTH/8-1:0] m1_sel_i,
    output logic [DATA_WIDTH-1:0]   m1_dat_o,
    output logic                    m1_ack_o,
    output logic                    m1_err_o,
    output logic                    s_cyc_o,
    output logic                    s_stb_o,
    output logic                    s_we_o,
    output logic [ADDR_WIDTH-1:0]   s_adr_o,
    output logic [DATA_WIDTH-1:0]   s_dat_o,
    output logic [DATA_WIDTH/8-1:0] s_sel_o,
    input  logic [DATA_WIDTH-1:0]   s_dat_i,
    input  logic                    s_ack_i,
    input  logic                    s_err_i,
    output logic [1:0]              grant_o,
    output logic                    timeout_o
);

    arb_state_e state_q, state_d;
    logic       last_owner_q, last_owner_d;
    logic       wd_err;

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        unique case (state_q)
            IDLE: begin
                // On a tie the master that did not own the bus last time wins.
                if (m0_cyc_i && m1_cyc_i) begin
                    state_d = last_owner_q ? OWN0 : OWN1;
                end else if (m0_cyc_i) begin
                    state_d = OWN0;
                end else if (m1_cyc_i) begin
                    state_d = OWN1;
                end
            end
            OWN0: begin
                if (!m0_cyc_i) begin
                    state_d      = IDLE;
                    last_owner_d = 1'b0;
                end
            end
            OWN1: begin
                if (!m1_cyc_i) begin
                    state_d      = IDLE;
                    last_owner_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_owner_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
        end
    end

    always_comb begin
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        s_we_o    = 1'b0;
        s_adr_o   = '0;
        s_dat_o   = '0;
        s_sel_o   = '0;
        m0_dat_o  = '0;
        m0_ack_o  = 1'b0;
        m0_err_o  = 1'b0;
        m1_dat_o  = '0;
        m1_ack_o  = 1'b0;
        m1_err_o  = 1'b0;
        grant_o   = GRANT_NONE;
        unique case (state_q)
            OWN0: begin
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i;
                s_we_o   = m0_we_i;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_sel_o  = m0_sel_i;
                m0_dat_o = s_dat_i;
                m0_ack_o = s_ack_i;
                m0_err_o = s_err_i | wd_err;
                grant_o  = GRANT_M0;
            end
            OWN1: begin
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i;
                s_we_o   = m1_we_i;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_sel_o  = m1_sel_i;
                m1_dat_o = s_dat_i;
                m1_ack_o = s_ack_i;
                m1_err_o = s_err_i | wd_err;
                grant_o  = GRANT_M1;
            end
            default: ;
        endcase
    end

    assign timeout_o = wd_err;

    wb_bus_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk   (clk),
        .reset (reset),
        .stb   (s_stb_o),
        .ack   (s_ack_i),
        .err   (s_err_i),
        .clr   (state_d != state_q),
        .fire  (wd_err)
    );

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Directed self-checking bench for wb_master_arbiter (watchdog enabled and disabled instances).
module tb_wb_master_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          m0_cyc_i, m0_stb_i, m0_we_i;
    logic [AW-1:0] m0_adr_i;
    logic [DW-1:0] m0_dat_i;
    logic [SW-1:0] m0_sel_i;
    logic          m1_cyc_i, m1_stb_i, m1_we_i;
    logic [AW-1:0] m1_adr_i;
    logic [DW-1:0] m1_dat_i;
    logic [SW-1:0] m1_sel_i;
    logic [DW-1:0] s_dat_i;
    logic          s_ack_i, s_err_i;

    logic [DW-1:0] m0_dat_o, m1_dat_o, s_dat_o;
    logic          m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic          s_cyc_o, s_stb_o, s_we_o, timeout_o;
    logic [AW-1:0] s_adr_o;
    logic [SW-1:0] s_sel_o;
    logic [1:0]    grant_o;

    logic [DW-1:0] z_m0_dat_o, z_m1_dat_o, z_s_dat_o;
    logic          z_m0_ack_o, z_m0_err_o, z_m1_ack_o, z_m1_err_o;
    logic          z_s_cyc_o, z_s_stb_o, z_s_we_o, z_timeout_o;
    logic [AW-1:0] z_s_adr_o;
    logic [SW-1:0] z_s_sel_o;
    logic [1:0]    z_grant_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_master_arbiter #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (255)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .m0_cyc_i  (m0_cyc_i),
        .m0_stb_i  (m0_stb_i),
        .m0_we_i   (m0_we_i),
        .m0_adr_i  (m0_adr_i),
        .m0_dat_i  (m0_dat_i),
        .m0_sel_i  (m0_sel_i),
        .m0_dat_o  (m0_dat_o),
        .m0_ack_o  (m0_ack_o),
        .m0_err_o  (m0_err_o),
        .m1_cyc_i  (m1_cyc_i),
        .m1_stb_i  (m1_stb_i),
        .m1_we_i   (m1_we_i),
        .m1_adr_i  (m1_adr_i),
        .m1_dat_i  (m1_dat_i),
        .m1_sel_i  (m1_sel_i),
        .m1_dat_o  (m1_dat_o),
        .m1_ack_o  (m1_ack_o),
        .m1_err_o  (m1_err_o),
        .s_cyc_o   (s_cyc_o),
        .s_stb_o   (s_stb_o),
        .s_we_o    (s_we_o),
        .s_adr_o   (s_adr_o),
        .s_dat_o   (s_dat_o),
        .s_sel_o   (s_sel_o),
        .s_dat_i   (s_dat_i),
        .s_ack_i   (s_ack_i),
        .s_err_i   (s_err_i),
        .grant_o   (grant_o),
        .timeout_o (timeout_o)
    );

    wb_master_arbiter #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (0)
    ) dut_nowd (
        .clk       (clk),
        .reset     (reset),
        .m0_cyc_i  (m0_cyc_i),
        .m0_stb_i  (m0_stb_i),
        .m0_we_i   (m0_we_i),
        .m0_adr_i  (m0_adr_i),
        .m0_dat_i  (m0_dat_i),
        .m0_sel_i  (m0_sel_i),
        .m0_dat_o  (z_m0_dat_o),
        .m0_ack_o  (z_m0_ack_o),
        .m0_err_o  (z_m0_err_o),
        .m1_cyc_i  (m1_cyc_i),
        .m1_stb_i  (m1_stb_i),
        .m1_we_i   (m1_we_i),
        .m1_adr_i  (m1_adr_i),
        .m1_dat_i  (m1_dat_i),
        .m1_sel_i  (m1_sel_i),
        .m1_dat_o  (z_m1_dat_o),
        .m1_ack_o  (z_m1_ack_o),
        .m1_err_o  (z_m1_err_o),
        .s_cyc_o   (z_s_cyc_o),
        .s_stb_o   (z_s_stb_o),
        .s_we_o    (z_s_we_o),
        .s_adr_o   (z_s_adr_o),
        .s_dat_o   (z_s_dat_o),
        .s_sel_o   (z_s_sel_o),
        .s_dat_i   (s_dat_i),
        .s_ack_i   (s_ack_i),
        .s_err_i   (s_err_i),
        .grant_o   (z_grant_o),
        .timeout_o (z_timeout_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_adr_i = '0; m0_dat_i = '0; m0_sel_i = '0;
        m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_adr_i = '0; m1_dat_i = '0; m1_sel_i = '0;
        s_dat_i = '0; s_ack_i = 0; s_err_i = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_grant"}, 64'(grant_o), 64'h0);
        check({tag, "_scyc"},  64'({s_cyc_o, s_stb_o, s_we_o}), 64'h0);
        check({tag, "_sbus"},  64'({s_adr_o, s_dat_o, s_sel_o}), 64'h0);
        check({tag, "_m0rsp"}, 64'({m0_dat_o, m0_ack_o, m0_err_o}), 64'h0);
        check({tag, "_m1rsp"}, 64'({m1_dat_o, m1_ack_o, m1_err_o}), 64'h0);
        check({tag, "_tmo"},   64'(timeout_o), 64'h0);
    endtask

    initial begin
        logic seen;
        logic zseen;

        clear_inputs();
        reset = 1'b1;
        settle();
        check_all_zero("rst");
        tick();
        tick();
        #3 reset = 1'b0;

        // Single master 0 transfer.
        tick();
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h0000_1000; m0_sel_i = 4'hF;
        settle();
        check("t1_idle_grant", 64'(grant_o), 64'h0);
        check("t1_idle_scyc", 64'(s_cyc_o), 64'h0);
        tick();
        check("t1_grant", 64'(grant_o), 64'h1);
        check("t1_sadr", 64'(s_adr_o), 64'h0000_1000);
        check("t1_scyc", 64'({s_cyc_o, s_stb_o, s_sel_o}), 64'h3F);
        s_ack_i = 1; s_dat_i = 32'hDEAD_BEEF;
        settle();
        check("t1_m0dat", 64'({m0_dat_o, m0_ack_o}), {31'h0, 32'hDEAD_BEEF, 1'b1});
        check("t1_m1rsp", 64'({m1_dat_o, m1_ack_o, m1_err_o}), 64'h0);
        tick();
        clear_inputs();
        settle();
        check("t1_drop_grant", 64'(grant_o), 64'h1);
        tick();
        check("t1_back_idle", 64'(grant_o), 64'h0);

        // Tie from reset goes to master 0, then round-robin.
        reset = 1'b1;
        settle();
        reset = 1'b0;
        m0_cyc_i = 1; m1_cyc_i = 1;
        tick();
        check("t2_tie0", 64'(grant_o), 64'h1);
        m0_cyc_i = 0;
        tick();
        check("t2_gap", 64'(grant_o), 64'h0);
        tick();
        check("t2_m1", 64'(grant_o), 64'h2);
        m1_cyc_i = 0;
        tick();
        check("t2_idle", 64'(grant_o), 64'h0);
        m0_cyc_i = 1; m1_cyc_i = 1;
        tick();
        check("t2_tie1", 64'(grant_o), 64'h1);
        clear_inputs();
        tick();

        // Master 1 burst holds off master 0.
        m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h0000_2000;
        tick();
        check("t3_m1own", 64'(grant_o), 64'h2);
        m0_cyc_i = 1; m0_stb_i = 1;
        for (int i = 0; i < 4; i++) begin
            s_ack_i = 1; s_dat_i = 32'(i + 16);
            settle();
            check("t3_beat", 64'({grant_o, m1_ack_o, m1_dat_o, m0_ack_o}),
                  {29'h0, 2'b10, 1'b1, 32'(i + 16), 1'b0});
            tick();
        end
        s_ack_i = 0; s_dat_i = '0;
        m1_cyc_i = 0; m1_stb_i = 0;
        settle();
        check("t3_drop", 64'({grant_o, m0_ack_o}), 64'h4);
        tick();
        check("t3_gap", 64'({grant_o, m0_ack_o}), 64'h0);
        tick();
        check("t3_m0own", 64'({grant_o, m0_ack_o}), 64'h2);
        clear_inputs();
        tick();

        // Watchdog: first stalled strobe cycle is N, error pulses at N+255.
        m0_cyc_i = 1; m0_stb_i = 1;
        tick();
        check("t4_n0", 64'({grant_o, m0_err_o, timeout_o}), 64'h4);
        seen = 0; zseen = 0;
        for (int k = 1; k < 255; k++) begin
            tick();
            seen  = seen | timeout_o | m0_err_o;
            zseen = zseen | z_timeout_o | z_m0_err_o;
        end
        check("t4_early", 64'(seen), 64'h0);
        tick();
        check("t4_fire", 64'({m0_err_o, timeout_o, m1_err_o}), 64'h6);
        zseen = zseen | z_timeout_o | z_m0_err_o;
        tick();
        check("t4_oneshot", 64'({m0_err_o, timeout_o}), 64'h0);
        zseen = zseen | z_timeout_o | z_m0_err_o;

        // Second window with ack landing on the timeout cycle.
        seen = 0;
        for (int k = 1; k < 255; k++) begin
            tick();
            seen  = seen | timeout_o;
            zseen = zseen | z_timeout_o | z_m0_err_o;
        end
        check("t5_early", 64'(seen), 64'h0);
        tick();
        s_ack_i = 1;
        settle();
        check("t5_ackerr", 64'({m0_ack_o, m0_err_o, timeout_o}), 64'h7);
        check("t5_nowd", 64'({z_m0_ack_o, z_m0_err_o, z_timeout_o}), 64'h4);
        tick();
        s_ack_i = 0;
        settle();
        check("t5_after", 64'({m0_ack_o, m0_err_o, timeout_o}), 64'h0);
        seen = 0;
        for (int k = 1; k < 255; k++) begin
            tick();
            seen  = seen | timeout_o;
            zseen = zseen | z_timeout_o | z_m0_err_o;
        end
        check("t5_restart_early", 64'(seen), 64'h0);
        tick();
        check("t5_restart_fire", 64'(timeout_o), 64'h1);
        zseen = zseen | z_timeout_o | z_m0_err_o;
        check("t4_nowd_never", 64'(zseen), 64'h0);
        clear_inputs();
        tick();

        // Asynchronous reset while master 1 owns the bus.
        m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1; m1_adr_i = 32'h0000_3000;
        m1_dat_i = 32'h1234_5678; m1_sel_i = 4'h3;
        tick();
        check("t6_m1own", 64'({grant_o, s_cyc_o, s_we_o}), 64'hB);
        s_ack_i = 1; s_dat_i = 32'h55;
        settle();
        check("t6_m1rsp", 64'({m1_dat_o, m1_ack_o}), 64'hAB);
        #1 reset = 1'b1;
        #1;
        check_all_zero("t6_async");
        #1 reset = 1'b0;
        s_ack_i = 0; s_dat_i = '0;
        m0_cyc_i = 1;
        tick();
        check("t6_tie_m0", 64'(grant_o), 64'h1);

        clear_inputs();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
